// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way, W-bit operand select stage with a registered output and a
// valid/ready handshake. A two-entry main/skid buffer absorbs backpressure,
// which is what lets in_ready come straight from a flop. The select is resolved
// at acceptance, so each held entry is only the chosen word plus an error bit.
module mux_n_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err
);

    if ((NUM_IN < 2) || (NUM_IN > 16) || ((2 ** SEL_W) < NUM_IN)) begin : g_param_check
        $error("mux_n_pipe: NUM_IN must be 2..16 and 2**SEL_W must be >= NUM_IN");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Resolve the select into {err, word}; an out-of-range index yields zero data with err set.
    function automatic logic [WIDTH:0] select_entry(
        input logic [NUM_IN*WIDTH-1:0] data,
        input logic [SEL_W-1:0]        sel
    );
        logic [WIDTH:0] entry;
        entry = {1'b1, {WIDTH{1'b0}}};
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                entry = {1'b0, data[k*WIDTH +: WIDTH]};
            end
        end
        return entry;
    endfunction

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic               main_err_q,  main_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               skid_err_q,  skid_err_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;

    logic               acc_s;
    logic               pop_s;
    logic [WIDTH:0]     new_entry_s;

    assign acc_s       = in_valid && in_ready_q;
    assign pop_s       = out_valid_q && out_ready;
    assign new_entry_s = select_entry(in_data, in_sel);

    // Next-state and buffer-load decisions for the main/skid pair.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        if (flush) begin
            // Everything held is discarded; an entry offered now is not taken.
            state_d     = ST_EMPTY;
            skid_data_d = {WIDTH{1'b0}};
            skid_err_d  = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_d     = ST_ONE;
                        main_data_d = new_entry_s[WIDTH-1:0];
                        main_err_d  = new_entry_s[WIDTH];
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && !pop_s) begin
                        state_d     = ST_TWO;
                        skid_data_d = new_entry_s[WIDTH-1:0];
                        skid_err_d  = new_entry_s[WIDTH];
                    end else if (acc_s && pop_s) begin
                        state_d     = ST_ONE;
                        main_data_d = new_entry_s[WIDTH-1:0];
                        main_err_d  = new_entry_s[WIDTH];
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can move the state.
                    if (pop_s) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_err_d  = skid_err_q;
                        skid_data_d = {WIDTH{1'b0}};
                        skid_err_d  = 1'b0;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    skid_data_d = {WIDTH{1'b0}};
                    skid_err_d  = 1'b0;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= {WIDTH{1'b0}};
            main_err_q  <= 1'b0;
            skid_data_q <= {WIDTH{1'b0}};
            skid_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = main_data_q;
    assign out_sel_err = main_err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: directed vectors on the default configuration plus a
// random valid/ready run on an 8-bit, 5-input, 3-bit-select instance. Both are
// checked every cycle against a FIFO-of-expected-entries model.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit b_done = 1'b0;

    // Instance A: default parameters
    logic        rst_a, flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_sel_err_a;
    logic [95:0] in_data_a;
    logic [1:0]  in_sel_a;
    logic [31:0] out_data_a;

    // Instance B: WIDTH=8, NUM_IN=5, SEL_W=3
    logic        rst_b, flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sel_err_b;
    logic [39:0] in_data_b;
    logic [2:0]  in_sel_b;
    logic [7:0]  out_data_b;

    mux_n_pipe dut_a (
        .clk(clk), .rst(rst_a), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_sel(in_sel_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_sel_err(out_sel_err_a)
    );

    mux_n_pipe #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) dut_b (
        .clk(clk), .rst(rst_b), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_sel(in_sel_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_sel_err(out_sel_err_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Expected {err, word} for an accepted set
    function automatic logic [32:0] exp_a(input logic [95:0] d, input logic [1:0] s);
        if (s < 2'd3) return {1'b0, d[s*32 +: 32]};
        else          return {1'b1, 32'h0000_0000};
    endfunction

    function automatic logic [8:0] exp_b(input logic [39:0] d, input logic [2:0] s);
        if (s < 3'd5) return {1'b0, d[s*8 +: 8]};
        else          return {1'b1, 8'h00};
    endfunction

    // Model: queue of entries the block currently holds (max two)
    logic [32:0] qa[$];
    logic [8:0]  qb[$];

    initial forever begin
        @(posedge clk);
        if (rst_a || flush_a) begin
            qa.delete();
        end else if (out_ready_a && qa.size() > 0 && in_valid_a && qa.size() < 2) begin
            void'(qa.pop_front());
            qa.push_back(exp_a(in_data_a, in_sel_a));
        end else if (out_ready_a && qa.size() > 0) begin
            void'(qa.pop_front());
        end else if (in_valid_a && qa.size() < 2) begin
            qa.push_back(exp_a(in_data_a, in_sel_a));
        end

        if (rst_b || flush_b) begin
            qb.delete();
        end else if (out_ready_b && qb.size() > 0 && in_valid_b && qb.size() < 2) begin
            void'(qb.pop_front());
            qb.push_back(exp_b(in_data_b, in_sel_b));
        end else if (out_ready_b && qb.size() > 0) begin
            void'(qb.pop_front());
        end else if (in_valid_b && qb.size() < 2) begin
            qb.push_back(exp_b(in_data_b, in_sel_b));
        end
    end

    // Per-cycle comparison against the model, on the falling edge
    logic       stall_b_prev = 1'b0;
    logic [8:0] held_b_prev  = 9'h000;
    always @(negedge clk) begin
        chk("a_in_ready", 64'(in_ready_a), 64'(qa.size() < 2));
        chk("a_out_valid", 64'(out_valid_a), 64'(qa.size() > 0));
        if (qa.size() > 0) begin
            chk("a_out_data", 64'(out_data_a), 64'(qa[0][31:0]));
            chk("a_out_sel_err", 64'(out_sel_err_a), 64'(qa[0][32]));
        end
        chk("b_in_ready", 64'(in_ready_b), 64'(qb.size() < 2));
        chk("b_out_valid", 64'(out_valid_b), 64'(qb.size() > 0));
        if (qb.size() > 0) begin
            chk("b_out_data", 64'(out_data_b), 64'(qb[0][7:0]));
            chk("b_out_sel_err", 64'(out_sel_err_b), 64'(qb[0][8]));
        end
        if (stall_b_prev) begin
            chk("b_stall_stable", 64'({out_sel_err_b, out_data_b}), 64'(held_b_prev));
        end
        stall_b_prev = out_valid_b && !out_ready_b && !flush_b && !rst_b;
        held_b_prev  = {out_sel_err_b, out_data_b};
    end

    // Directed sequence on instance A
    initial begin : stim_a
        rst_a = 1'b1; flush_a = 1'b0; in_valid_a = 1'b0; in_sel_a = 2'd0; out_ready_a = 1'b0;
        in_data_a = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
        step(); step();
        rst_a = 1'b0;
        chk("reset_out_valid", 64'(out_valid_a), 64'h0);
        chk("reset_out_data", 64'(out_data_a), 64'h0);
        chk("reset_in_ready", 64'(in_ready_a), 64'h1);
        chk("reset_out_sel_err", 64'(out_sel_err_a), 64'h0);

        // streaming, one entry per cycle
        out_ready_a = 1'b1; in_valid_a = 1'b1;
        in_sel_a = 2'd0; step();
        chk("stream0_valid", 64'(out_valid_a), 64'h1);
        chk("stream0_data", 64'(out_data_a), 64'h11);
        chk("stream0_err", 64'(out_sel_err_a), 64'h0);
        in_sel_a = 2'd1; step();
        chk("stream1_data", 64'(out_data_a), 64'h22);
        in_sel_a = 2'd2; step();
        chk("stream2_data", 64'(out_data_a), 64'h33);

        // out-of-range select
        in_sel_a = 2'd3; step();
        chk("oor_data", 64'(out_data_a), 64'h0);
        chk("oor_err", 64'(out_sel_err_a), 64'h1);
        in_sel_a = 2'd1; step();
        chk("after_oor_data", 64'(out_data_a), 64'h22);
        chk("after_oor_err", 64'(out_sel_err_a), 64'h0);
        in_valid_a = 1'b0; step();
        chk("drain_valid", 64'(out_valid_a), 64'h0);

        // backpressure: A=0x11, B=0x22, C=0x33
        out_ready_a = 1'b0; in_valid_a = 1'b1;
        in_sel_a = 2'd0; step();
        chk("bp_a_data", 64'(out_data_a), 64'h11);
        chk("bp_a_ready", 64'(in_ready_a), 64'h1);
        in_sel_a = 2'd1; step();
        chk("bp_b_ready", 64'(in_ready_a), 64'h0);
        chk("bp_b_data", 64'(out_data_a), 64'h11);
        in_sel_a = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_c_ready", 64'(in_ready_a), 64'h0);
            chk("bp_c_hold", 64'(out_data_a), 64'h11);
        end
        out_ready_a = 1'b1; step();
        chk("bp_out_b", 64'(out_data_a), 64'h22);
        chk("bp_ready_back", 64'(in_ready_a), 64'h1);
        step();
        chk("bp_out_c", 64'(out_data_a), 64'h33);
        chk("bp_out_c_valid", 64'(out_valid_a), 64'h1);
        in_valid_a = 1'b0; step();
        chk("bp_empty", 64'(out_valid_a), 64'h0);

        // flush in state TWO with an entry offered
        out_ready_a = 1'b0; in_valid_a = 1'b1;
        in_sel_a = 2'd0; step();
        in_sel_a = 2'd1; step();
        chk("flush_pre_two", 64'(in_ready_a), 64'h0);
        flush_a = 1'b1; in_sel_a = 2'd2; step();
        chk("flush_valid", 64'(out_valid_a), 64'h0);
        chk("flush_ready", 64'(in_ready_a), 64'h1);
        flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_ghost", 64'(out_valid_a), 64'h0);
        end

        // reset while in state ONE, together with flush/in_valid/out_ready
        out_ready_a = 1'b0; in_valid_a = 1'b1; in_sel_a = 2'd2; step();
        chk("rst_pre_data", 64'(out_data_a), 64'h33);
        rst_a = 1'b1; flush_a = 1'b1; out_ready_a = 1'b1; step();
        chk("rst_mid_valid", 64'(out_valid_a), 64'h0);
        chk("rst_mid_data", 64'(out_data_a), 64'h0);
        chk("rst_mid_err", 64'(out_sel_err_a), 64'h0);
        chk("rst_mid_ready", 64'(in_ready_a), 64'h1);
        rst_a = 1'b0; flush_a = 1'b0; in_valid_a = 1'b0; step();
        chk("rst_mid_empty", 64'(out_valid_a), 64'h0);
        in_valid_a = 1'b1; in_sel_a = 2'd0; step();
        chk("rst_recover_data", 64'(out_data_a), 64'h11);
        in_valid_a = 1'b0; step();

        for (int i = 0; i < 2000 && !b_done; i++) step();
        if (!b_done) begin
            chk("sweep_timeout", 64'(b_done), 64'h1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Random valid/ready sweep on instance B
    initial begin : stim_b
        rst_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b0; in_sel_b = 3'd0; out_ready_b = 1'b0;
        in_data_b = 40'h0;
        step(); step();
        rst_b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            in_valid_b  = 1'($urandom_range(0, 1));
            out_ready_b = 1'($urandom_range(0, 1));
            in_sel_b    = 3'($urandom_range(0, 7));
            in_data_b   = 40'({$urandom, $urandom});
            flush_b     = ($urandom_range(0, 63) == 0);
            step();
        end
        in_valid_b = 1'b0; flush_b = 1'b0;
        b_done = 1'b1;
    end

endmodule
